// File: rtl/frame_arb.sv
// frame_arb: packet-granular round-robin arbiter feeding one byte stream.
// Each grant covers exactly one contiguous frame; the selected port's bytes
// pass through a single register stage onto rxd/rx_dv. After every grant an
// enforced idle gap separates frames. Start-of-frame timeout and frame-length
// violations are reported as one-cycle error pulses.
module frame_arb #(
  parameter int NUM_REQ  = 4,
  parameter int IFG      = 2,
  parameter int START_TO = 16,
  parameter int MAX_LEN  = 1518
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   in_req,
  input  logic [NUM_REQ-1:0]   in_dv,
  input  logic [8*NUM_REQ-1:0] in_rxd,
  output logic [NUM_REQ-1:0]   in_gnt,
  output logic [7:0]           rxd,
  output logic                 rx_dv,
  output logic                 busy,
  output logic [2:0]           cur_port,
  output logic                 err_timeout,
  output logic                 err_len
);

  localparam int LEN_W  = $clog2(MAX_LEN + 1);
  localparam int WAIT_W = $clog2(START_TO + 1);
  localparam int GAP_W  = $clog2(IFG + 1);

  // Terminal counter values; the wait and gap counters act one edge before
  // they would reach their limit so the transition lands on the limit edge.
  localparam logic [LEN_W-1:0]   LEN_LIMIT = LEN_W'(MAX_LEN);
  localparam logic [WAIT_W-1:0]  WAIT_LAST = WAIT_W'(START_TO - 1);
  localparam logic [GAP_W-1:0]   GAP_LAST  = GAP_W'(IFG - 1);
  localparam logic [NUM_REQ-1:0] GNT_ONE   = NUM_REQ'(1);
  localparam logic [2:0]         PORT_LAST = 3'(NUM_REQ - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_GRANT = 3'd1,
    S_XFER  = 3'd2,
    S_DRAIN = 3'd3,
    S_GAP   = 3'd4
  } state_t;

  state_t               r_state;
  state_t               w_next_state;

  logic [NUM_REQ-1:0]   r_gnt;
  logic [7:0]           r_rxd;
  logic                 r_rx_dv;
  logic [2:0]           r_cur_port;
  logic [2:0]           r_last_port;
  logic [LEN_W-1:0]     r_len;
  logic [WAIT_W-1:0]    r_wait;
  logic [GAP_W-1:0]     r_gap;
  logic                 r_err_to;
  logic                 r_err_len;

  logic [NUM_REQ-1:0]   w_gnt_nxt;
  logic [7:0]           w_rxd_nxt;
  logic                 w_rx_dv_nxt;
  logic [2:0]           w_cur_nxt;
  logic [2:0]           w_last_nxt;
  logic [LEN_W-1:0]     w_len_nxt;
  logic [WAIT_W-1:0]    w_wait_nxt;
  logic [GAP_W-1:0]     w_gap_nxt;
  logic                 w_err_to_nxt;
  logic                 w_err_len_nxt;

  logic                 w_sel_dv;
  logic                 w_sel_req;
  logic [7:0]           w_sel_rxd;
  logic                 w_arb_found;
  logic [2:0]           w_arb_idx;

  // Pick out the granted port's request, valid and data; other ports are ignored.
  always_comb begin
    w_sel_dv  = 1'b0;
    w_sel_req = 1'b0;
    w_sel_rxd = 8'd0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_cur_port == 3'(i)) begin
        w_sel_dv  = in_dv[i];
        w_sel_req = in_req[i];
        w_sel_rxd = in_rxd[8*i +: 8];
      end
    end
  end

  // Round-robin search: first requester at distance 1, 2, ... after last_port.
  always_comb begin
    w_arb_found = 1'b0;
    w_arb_idx   = 3'd0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!w_arb_found && in_req[i] &&
            (r_last_port == 3'((i - k + NUM_REQ) % NUM_REQ))) begin
          w_arb_found = 1'b1;
          w_arb_idx   = 3'(i);
        end
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_arb_found) w_next_state = S_GRANT;
      end
      S_GRANT: begin
        if (w_sel_dv)                w_next_state = S_XFER;
        else if (!w_sel_req)         w_next_state = S_GAP;
        else if (r_wait == WAIT_LAST) w_next_state = S_GAP;
      end
      S_XFER: begin
        if (!w_sel_dv)               w_next_state = S_GAP;
        else if (r_len == LEN_LIMIT) w_next_state = S_DRAIN;
      end
      S_DRAIN: begin
        if (!w_sel_dv) w_next_state = S_GAP;
      end
      S_GAP: begin
        if (r_gap == GAP_LAST) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Output decode: next values of the registered outputs and the counters.
  // rxd defaults to zero so it is only non-zero while rx_dv is high.
  always_comb begin
    w_gnt_nxt     = r_gnt;
    w_rxd_nxt     = 8'd0;
    w_rx_dv_nxt   = 1'b0;
    w_cur_nxt     = r_cur_port;
    w_last_nxt    = r_last_port;
    w_len_nxt     = r_len;
    w_wait_nxt    = r_wait;
    w_gap_nxt     = r_gap;
    w_err_to_nxt  = 1'b0;
    w_err_len_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_arb_found) begin
          w_gnt_nxt  = GNT_ONE << w_arb_idx;
          w_cur_nxt  = w_arb_idx;
          w_last_nxt = w_arb_idx;
          w_wait_nxt = '0;
          w_len_nxt  = '0;
        end
      end
      S_GRANT: begin
        if (w_sel_dv) begin
          w_rx_dv_nxt = 1'b1;
          w_rxd_nxt   = w_sel_rxd;
          w_len_nxt   = LEN_W'(1);
        end else if (!w_sel_req) begin
          // Port abandoned its request before sending: quiet release.
          w_gnt_nxt = '0;
          w_gap_nxt = '0;
        end else if (r_wait == WAIT_LAST) begin
          w_err_to_nxt = 1'b1;
          w_gnt_nxt    = '0;
          w_gap_nxt    = '0;
          w_wait_nxt   = r_wait + 1'b1;
        end else begin
          w_wait_nxt = r_wait + 1'b1;
        end
      end
      S_XFER: begin
        if (!w_sel_dv) begin
          w_gnt_nxt = '0;
          w_gap_nxt = '0;
        end else if (r_len == LEN_LIMIT) begin
          // Byte MAX_LEN+1 is swallowed; the rest of the frame is drained.
          w_err_len_nxt = 1'b1;
        end else begin
          w_rx_dv_nxt = 1'b1;
          w_rxd_nxt   = w_sel_rxd;
          w_len_nxt   = r_len + 1'b1;
        end
      end
      S_DRAIN: begin
        if (!w_sel_dv) begin
          w_gnt_nxt = '0;
          w_gap_nxt = '0;
        end
      end
      S_GAP: begin
        if (r_gap != GAP_LAST) w_gap_nxt = r_gap + 1'b1;
      end
      default: begin
        w_gnt_nxt = '0;
      end
    endcase
  end

  // Output and counter registers; reset cuts any frame in flight silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gnt       <= '0;
      r_rxd       <= 8'd0;
      r_rx_dv     <= 1'b0;
      r_cur_port  <= 3'd0;
      r_last_port <= PORT_LAST;
      r_len       <= '0;
      r_wait      <= '0;
      r_gap       <= '0;
      r_err_to    <= 1'b0;
      r_err_len   <= 1'b0;
    end else begin
      r_gnt       <= w_gnt_nxt;
      r_rxd       <= w_rxd_nxt;
      r_rx_dv     <= w_rx_dv_nxt;
      r_cur_port  <= w_cur_nxt;
      r_last_port <= w_last_nxt;
      r_len       <= w_len_nxt;
      r_wait      <= w_wait_nxt;
      r_gap       <= w_gap_nxt;
      r_err_to    <= w_err_to_nxt;
      r_err_len   <= w_err_len_nxt;
    end
  end

  assign in_gnt      = r_gnt;
  assign rxd         = r_rxd;
  assign rx_dv       = r_rx_dv;
  assign cur_port    = r_cur_port;
  assign err_timeout = r_err_to;
  assign err_len     = r_err_len;
  assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_frame_arb.sv
// Testbench for frame_arb: scenario tasks with a byte scoreboard on rxd.
module tb_frame_arb;
  localparam int NR    = 4;
  localparam int IFG_C = 2;
  localparam int STO   = 16;
  localparam int MLEN  = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [3:0]  req = '0;
  logic [3:0]  dv = '0;
  logic [31:0] din = '0;
  logic [3:0]  in_gnt;
  logic [7:0]  rxd;
  logic        rx_dv;
  logic        busy;
  logic [2:0]  cur_port;
  logic        err_timeout;
  logic        err_len;

  int total = 0;
  int bad   = 0;
  int cnt_to  = 0;
  int cnt_len = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;

  frame_arb #(.NUM_REQ(NR), .IFG(IFG_C), .START_TO(STO), .MAX_LEN(MLEN)) dut (
    .clk(clk), .rst_n(rst_n), .in_req(req), .in_dv(dv), .in_rxd(din),
    .in_gnt(in_gnt), .rxd(rxd), .rx_dv(rx_dv), .busy(busy), .cur_port(cur_port),
    .err_timeout(err_timeout), .err_len(err_len)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, bench did not finish");
    $fatal(1, "watchdog");
  end

  // Scoreboard monitor: every forwarded byte must be the next expected one.
  always @(negedge clk) begin
    if (rst_n) begin
      if (err_timeout) cnt_to++;
      if (err_len) cnt_len++;
      total++;
      if (rx_dv) begin
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL sb_unexpected: got rxd=%02h, required no byte", rxd);
        end else begin
          mon_exp = exp_q.pop_front();
          if (rxd !== mon_exp) begin
            bad++;
            $display("FAIL sb_data: got rxd=%02h, required %02h", rxd, mon_exp);
          end
        end
        total++;
        if (err_timeout || err_len) begin
          bad++;
          $display("FAIL err_with_dv: got err pulse with rx_dv=1, required none");
        end
      end else if (rxd !== 8'h00) begin
        bad++;
        $display("FAIL rxd_idle: got rxd=%02h with rx_dv=0, required 00", rxd);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_byte(input int p, input logic [7:0] b);
    dv  = 4'b0001 << p;
    din = (din & ~(32'hFF << (8*p))) | (32'(b) << (8*p));
  endtask

  task automatic wait_gnt(output int cyc);
    cyc = 0;
    while (in_gnt == 4'b0 && cyc < 40) begin
      tick();
      cyc++;
    end
  endtask

  function automatic int oh2idx(input logic [3:0] g);
    int r;
    r = -1;
    for (int i = 0; i < 4; i++) if (g[i]) r = i;
    return r;
  endfunction

  task automatic apply_reset;
    rst_n = 1'b0;
    req = '0;
    dv  = '0;
    din = '0;
    repeat (2) @(posedge clk);
    #1;
    exp_q.delete();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset;
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({in_gnt, rxd, rx_dv, busy, cur_port, err_timeout, err_len} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got gnt=%b rxd=%02h dv=%b busy=%b cur=%0d, required all 0",
               in_gnt, rxd, rx_dv, busy, cur_port);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    total++;
    if (busy !== 1'b0 || in_gnt !== 4'b0) begin
      bad++;
      $display("FAIL reset_idle: got busy=%b gnt=%b, required 0/0000", busy, in_gnt);
    end
  endtask

  task automatic test_single_frame;
    int t_to, t_len;
    apply_reset();
    t_to = cnt_to;
    t_len = cnt_len;
    req = 4'b0100;
    tick();
    total++;
    if (in_gnt !== 4'b0100 || cur_port !== 3'd2 || busy !== 1'b1) begin
      bad++;
      $display("FAIL single_grant: got gnt=%b cur=%0d busy=%b, required 0100/2/1",
               in_gnt, cur_port, busy);
    end
    for (int k = 0; k < 5; k++) begin
      drive_byte(2, 8'(8'h11 + k));
      exp_q.push_back(8'(8'h11 + k));
      tick();
      total++;
      if (rx_dv !== 1'b1 || rxd !== 8'(8'h11 + k)) begin
        bad++;
        $display("FAIL single_latency: byte %0d got dv=%b rxd=%02h, required 1/%02h",
                 k, rx_dv, rxd, 8'(8'h11 + k));
      end
    end
    dv = '0;
    req = '0;
    tick();
    total++;
    if (in_gnt !== 4'b0 || rx_dv !== 1'b0) begin
      bad++;
      $display("FAIL single_end: got gnt=%b dv=%b, required 0000/0", in_gnt, rx_dv);
    end
    repeat (3) tick();
    total++;
    if (exp_q.size() != 0 || cnt_to != t_to || cnt_len != t_len) begin
      bad++;
      $display("FAIL single_tail: got left=%0d to=%0d len=%0d, required 0/0/0",
               exp_q.size(), cnt_to - t_to, cnt_len - t_len);
    end
  endtask

  task automatic test_round_robin;
    int order[4] = '{0, 1, 3, 0};
    int cyc, p;
    apply_reset();
    req = 4'b1011;
    for (int f = 0; f < 4; f++) begin
      wait_gnt(cyc);
      total++;
      if (cyc != ((f == 0) ? 1 : IFG_C + 1)) begin
        bad++;
        $display("FAIL rr_gap: frame %0d got grant after %0d edges, required %0d",
                 f, cyc, (f == 0) ? 1 : IFG_C + 1);
      end
      p = oh2idx(in_gnt);
      total++;
      if (p != order[f]) begin
        bad++;
        $display("FAIL rr_order: frame %0d got port %0d, required %0d", f, p, order[f]);
      end
      if (p < 0) p = 0;
      for (int k = 0; k < 3; k++) begin
        drive_byte(p, 8'((p << 4) | k));
        exp_q.push_back(8'((p << 4) | k));
        tick();
      end
      dv = '0;
      tick();
      total++;
      if (in_gnt !== 4'b0 || rx_dv !== 1'b0) begin
        bad++;
        $display("FAIL rr_end: frame %0d got gnt=%b dv=%b, required 0000/0", f, in_gnt, rx_dv);
      end
    end
    req = '0;
    repeat (4) tick();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL rr_left: got %0d bytes unsent, required 0", exp_q.size());
    end
  endtask

  task automatic test_timeout;
    int t_to, t_len, cyc;
    logic held;
    apply_reset();
    t_to = cnt_to;
    t_len = cnt_len;
    req = 4'b0110;
    tick();
    total++;
    if (in_gnt !== 4'b0010) begin
      bad++;
      $display("FAIL to_grant: got gnt=%b, required 0010", in_gnt);
    end
    held = 1'b1;
    for (int i = 1; i < STO; i++) begin
      tick();
      if (in_gnt !== 4'b0010 || err_timeout !== 1'b0) held = 1'b0;
    end
    total++;
    if (held !== 1'b1) begin
      bad++;
      $display("FAIL to_early: got grant lost or early pulse=%b, required held grant", held);
    end
    tick();
    total++;
    if (err_timeout !== 1'b1 || in_gnt !== 4'b0) begin
      bad++;
      $display("FAIL to_pulse: got err_timeout=%b gnt=%b, required 1/0000", err_timeout, in_gnt);
    end
    wait_gnt(cyc);
    total++;
    if (cyc != IFG_C + 1 || in_gnt !== 4'b0100) begin
      bad++;
      $display("FAIL to_next: got gnt=%b after %0d edges, required 0100 after %0d",
               in_gnt, cyc, IFG_C + 1);
    end
    req = '0;
    repeat (4) tick();
    total++;
    if (cnt_to - t_to != 1 || cnt_len != t_len) begin
      bad++;
      $display("FAIL to_count: got to=%0d len=%0d, required 1/0", cnt_to - t_to, cnt_len - t_len);
    end
  endtask

  task automatic test_overlength;
    int t_len;
    apply_reset();
    t_len = cnt_len;
    req = 4'b0001;
    tick();
    total++;
    if (in_gnt !== 4'b0001) begin
      bad++;
      $display("FAIL ol_grant: got gnt=%b, required 0001", in_gnt);
    end
    for (int k = 0; k < 12; k++) begin
      drive_byte(0, 8'(8'hA0 + k));
      if (k < MLEN) exp_q.push_back(8'(8'hA0 + k));
      tick();
      total++;
      if (k < MLEN) begin
        if (rx_dv !== 1'b1 || err_len !== 1'b0) begin
          bad++;
          $display("FAIL ol_fwd: byte %0d got dv=%b err_len=%b, required 1/0", k, rx_dv, err_len);
        end
      end else if (k == MLEN) begin
        if (err_len !== 1'b1 || rx_dv !== 1'b0) begin
          bad++;
          $display("FAIL ol_pulse: got err_len=%b dv=%b, required 1/0", err_len, rx_dv);
        end
      end else begin
        if (in_gnt !== 4'b0001 || rx_dv !== 1'b0 || err_len !== 1'b0) begin
          bad++;
          $display("FAIL ol_drain: byte %0d got gnt=%b dv=%b err=%b, required 0001/0/0",
                   k, in_gnt, rx_dv, err_len);
        end
      end
    end
    dv = '0;
    req = '0;
    tick();
    total++;
    if (in_gnt !== 4'b0) begin
      bad++;
      $display("FAIL ol_release: got gnt=%b, required 0000", in_gnt);
    end
    tick();
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL ol_gap: got busy=%b mid-gap, required 1", busy);
    end
    tick();
    total++;
    if (busy !== 1'b0 || cnt_len - t_len != 1 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL ol_after: got busy=%b pulses=%0d left=%0d, required 0/1/0",
               busy, cnt_len - t_len, exp_q.size());
    end
  endtask

  task automatic test_abandon;
    int t_to, t_len, cyc;
    apply_reset();
    t_to = cnt_to;
    t_len = cnt_len;
    req = 4'b1000;
    tick();
    total++;
    if (in_gnt !== 4'b1000) begin
      bad++;
      $display("FAIL ab_grant: got gnt=%b, required 1000", in_gnt);
    end
    for (int i = 0; i < 4; i++) begin
      dv = (i % 2 == 0) ? 4'b0100 : 4'b0000;
      din[23:16] = 8'(8'hE0 + i);
      tick();
      total++;
      if (rx_dv !== 1'b0 || in_gnt !== 4'b1000) begin
        bad++;
        $display("FAIL ab_ignore: cycle %0d got dv=%b gnt=%b, required 0/1000", i, rx_dv, in_gnt);
      end
    end
    dv = '0;
    req = 4'b0100;
    tick();
    total++;
    if (in_gnt !== 4'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL ab_drop: got gnt=%b busy=%b, required 0000/1", in_gnt, busy);
    end
    wait_gnt(cyc);
    total++;
    if (cyc != IFG_C + 1 || in_gnt !== 4'b0100) begin
      bad++;
      $display("FAIL ab_resume: got gnt=%b after %0d edges, required 0100 after %0d",
               in_gnt, cyc, IFG_C + 1);
    end
    req = '0;
    repeat (4) tick();
    total++;
    if (cnt_to != t_to || cnt_len != t_len) begin
      bad++;
      $display("FAIL ab_errors: got to=%0d len=%0d, required 0/0", cnt_to - t_to, cnt_len - t_len);
    end
  endtask

  task automatic test_reset_mid;
    apply_reset();
    req = 4'b0010;
    tick();
    for (int k = 0; k < 3; k++) begin
      drive_byte(1, 8'(8'h30 + k));
      exp_q.push_back(8'(8'h30 + k));
      tick();
    end
    total++;
    if (rx_dv !== 1'b1 || cur_port !== 3'd1) begin
      bad++;
      $display("FAIL rm_inflight: got dv=%b cur=%0d, required 1/1", rx_dv, cur_port);
    end
    #1;
    rst_n = 1'b0;
    #1;
    total++;
    if ({in_gnt, rxd, rx_dv, busy, cur_port, err_timeout, err_len} !== '0) begin
      bad++;
      $display("FAIL rm_async: got gnt=%b rxd=%02h dv=%b busy=%b cur=%0d, required all 0",
               in_gnt, rxd, rx_dv, busy, cur_port);
    end
    exp_q.delete();
    dv = '0;
    req = 4'b0011;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    total++;
    if (in_gnt !== 4'b0001 || cur_port !== 3'd0) begin
      bad++;
      $display("FAIL rm_first: got gnt=%b cur=%0d, required 0001/0", in_gnt, cur_port);
    end
    req = '0;
    repeat (4) tick();
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_round_robin();
    test_timeout();
    test_overlength();
    test_abandon();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/frame_arb.md
# frame_arb

Packet-granular round-robin arbiter that shares the single byte-stream input (rxd/rx_dv) of the DUT datapath among NUM_REQ upstream requesters. Each requester requests, receives a grant, and sends one contiguous frame. The arbiter forwards that frame through a one-cycle registered mux, then enforces an inter-frame gap before it re-arbitrates. It also polices start-of-frame timeout and maximum frame length, and reports violations as one-cycle error pulses.

## Interface
- NUM_REQ, 4: number of requesters, 2..8.
- IFG, 2: forced idle cycles after each grant ends, ≥1.
- START_TO, 16: cycles a granted port may wait before its first in_dv.
- MAX_LEN, 1518: maximum bytes forwarded per frame.
- clk  in  1  single clock for the whole block.
- rst_n  in  1  asynchronous, active-low reset.
- in_req  in  NUM_REQ  per-port request; held high until the port's frame ends or it abandons.
- in_dv  in  NUM_REQ  per-port byte-valid; must be contiguous within one frame.
- in_rxd  in  8*NUM_REQ  per-port data; port i occupies bits [8i+7:8i].
- in_gnt  out  NUM_REQ  one-hot grant, registered.
- rxd  out  8  to DUT rxd.
- rx_dv  out  1  to DUT rx_dv.
- busy  out  1  high in any state other than IDLE.
- cur_port  out  3  index of the last or current granted port.
- err_timeout  out  1  one-cycle pulse.
- err_len  out  1  one-cycle pulse.

## Operation
- State machine states:
  - IDLE: if any in_req bit is high, select the first requesting index cyclically after last_port, set in_gnt, load cur_port, go to GRANT. Otherwise stay.
  - GRANT: wait for the first in_dv[p].
    - in_dv[p]=1: forward the byte, len=1, go to XFER.
    - in_req[p]=0 with in_dv[p]=0: drop grant, go to GAP (no error).
    - wait counter reaches START_TO: err_timeout pulse, drop grant, go to GAP.
  - XFER: forward the frame.
    - in_dv[p]=1 and len<MAX_LEN: forward the byte, len++.
    - in_dv[p]=1 and len==MAX_LEN: do not forward the byte, rx_dv=0, err_len pulse, go to DRAIN.
    - in_dv[p]=0: frame ends, rx_dv=0, drop grant, go to GAP.
  - DRAIN: keep the grant and discard bytes until the edge that samples in_dv[p]=0, then drop grant and go to GAP.
  - GAP: count IFG edges with rx_dv=0 and in_gnt=0, then go to IDLE.
- last_port updates on every grant. Arbitration is purely cyclic with no priority weighting. A single requester gets back-to-back grants, each separated by the gap.
- in_dv, in_rxd and in_req of non-granted ports are ignored in all states.
- The arbiter does not check in_req[p] during XFER or DRAIN; frame end is decided by in_dv only.
- rxd is 8'd0 whenever rx_dv=0.
- Counter widths:
  - len: clog2(MAX_LEN+1).
  - wait: clog2(START_TO+1).
  - gap: clog2(IFG+1).
  - No counter wraps. All clear on entry to their state.
- Reset (asynchronous, any state, including mid-frame):
  - state=IDLE; in_gnt, rxd, rx_dv, busy, cur_port, err_timeout, err_len all 0.
  - last_port=NUM_REQ-1, so port 0 wins first.
  - The frame in flight is cut with no error pulse.

## Timing
- Grant latency: the edge that samples in_req in IDLE asserts in_gnt after that edge. Minimum request-to-grant is one edge.
- Data latency: a byte sampled on in_rxd/in_dv[p] at edge E appears on rxd/rx_dv after edge E. This is one cycle, with no bubbles inside a frame.
- Frame end: the edge sampling in_dv[p]=0 clears rx_dv and in_gnt together.
- Gap: the next in_gnt asserts no earlier than IFG+1 edges after the frame-end edge. rx_dv is low for at least IFG+1 cycles between frames.
- Timeout: err_timeout pulses on the edge that makes wait==START_TO. in_gnt drops on the same edge.
- Error pulses last exactly one cycle and never coincide with rx_dv=1.
- busy follows the registered state: it rises with in_gnt and falls on entry to IDLE.

## Test plan
- Single frame:
  - Stimulus: reset, then port 2 requests and sends 5 bytes 0x11..0x15 starting 1 cycle after its grant.
  - Required: in_gnt=4'b0100; rxd shows 0x11..0x15 with rx_dv high for 5 contiguous cycles, each one cycle after its input; no error pulses.
- Round robin:
  - Stimulus: ports 0, 1 and 3 request continuously, each sending 3-byte frames; IFG=2.
  - Required: grant order 0, 1, 3, 0; rx_dv low for ≥3 cycles between frames.
- Start timeout:
  - Stimulus: port 1 granted but never asserts in_dv; START_TO=16.
  - Required: err_timeout pulses 16 edges after the grant; grant drops on that edge; the next requester is granted after the gap; rx_dv stays 0 throughout.
- Overlength:
  - Stimulus: MAX_LEN=8, port 0 sends 12 bytes.
  - Required: exactly 8 bytes forwarded; err_len pulses on the 9th sampled byte; grant is held until in_dv falls, then the gap runs.
- Abandon and ignore:
  - Stimulus: port 3 is granted, then drops in_req without sending; meanwhile port 2 toggles in_dv while not granted.
  - Required: no error pulse; port 2's bytes never appear on rxd; arbitration resumes after IFG.
- Reset mid-frame:
  - Stimulus: assert rst_n=0 asynchronously at the 3rd byte of a frame.
  - Required: all outputs are 0 immediately, without waiting for a clock edge; after release, port 0 wins if ports 0 and 1 both request.
